// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, press/release confirm FSM,
// long-press detection and a sticky press flag cleared by an acknowledge.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | button released and stable
// CONF_PRESS | pressed level seen, counting consecutive pressed samples
// PRESSED    | press confirmed, hold timer running toward the long press
// CONF_REL   | released level seen, counting consecutive released samples
module btn_debounce #(
    parameter int ACTIVE_LOW  = 1,
    parameter int DEB_CYCLES  = 1000000,
    parameter int LONG_CYCLES = 50000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    input  logic ack_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic pend_o
);

    localparam int DW = $clog2(DEB_CYCLES) + 1;
    localparam int HW = $clog2(LONG_CYCLES) + 1;

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    // Parking value one past the firing point, so long_o cannot repeat.
    localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CYCLES);

    // Raw pin level when the button is not pressed.
    localparam logic RAW_IDLE = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        IDLE,
        CONF_PRESS,
        PRESSED,
        CONF_REL
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            sync1_q, sync2_q;
    logic            s;
    logic            level_d, press_d, release_d, long_d, pend_d;

    // Two-flop synchronizer; reset to the released pin level so that reset
    // release never looks like an edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1_q <= RAW_IDLE;
            sync2_q <= RAW_IDLE;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Normalized button: 1 = pressed regardless of pin polarity.
    assign s = sync2_q ^ RAW_IDLE;

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            level_o   <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            long_o    <= 1'b0;
            pend_o    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            level_o   <= level_d;
            press_o   <= press_d;
            release_o <= release_d;
            long_o    <= long_d;
            pend_o    <= pend_d;
        end
    end

    // Next-state, counter updates and next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = CONF_PRESS;
                    cnt_d   = '0;
                end
            end

            CONF_PRESS: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    hold_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            PRESSED: begin
                if (!s) begin
                    state_d = CONF_REL;
                    cnt_d   = '0;
                end else if (hold_q == HOLD_LAST) begin
                    long_d = 1'b1;
                    hold_d = HOLD_SAT;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + 1'b1;
                end
            end

            CONF_REL: begin
                // Keep timing the hold through a release bounce, but never
                // fire from here; the firing point is left for PRESSED.
                if (hold_q < HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end
                if (s) begin
                    state_d = PRESSED;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        level_d = (state_d == PRESSED) || (state_d == CONF_REL);

        // Set dominates clear both on the confirming edge and during the
        // cycle press_o is visible, so an ack racing a press never drops it.
        pend_d = press_d | press_o | (pend_o & ~ack_i);
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with short debounce/long-press windows.
module tb_btn_debounce;

    logic clk_i = 1'b0;
    logic rst_i;
    logic btn_i;
    logic ack_i;
    logic level_o, press_o, release_o, long_o, pend_o;

    int n_vec = 0;
    int n_err = 0;

    btn_debounce #(
        .ACTIVE_LOW (1),
        .DEB_CYCLES (4),
        .LONG_CYCLES(10)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .btn_i    (btn_i),
        .ack_i    (ack_i),
        .level_o  (level_o),
        .press_o  (press_o),
        .release_o(release_o),
        .long_o   (long_o),
        .pend_o   (pend_o)
    );

    always #10 clk_i = ~clk_i;

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] outs;
        rst_i = 1'b0;
        btn_i = 1'b1;
        ack_i = 1'b0;
        #1;
        outs = {level_o, press_o, release_o, long_o, pend_o};
        n_vec++;
        if (outs !== 5'b0) begin
            n_err++;
            $display("FAIL reset_async outs=%b expected=%b", outs, 5'b0);
        end
        repeat (3) tick();
        rst_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            outs = {level_o, press_o, release_o, long_o, pend_o};
            n_vec++;
            if (outs !== 5'b0) begin
                n_err++;
                $display("FAIL reset_idle[%0d] outs=%b expected=%b", i, outs, 5'b0);
            end
        end
    endtask

    task automatic test_press();
        btn_i = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            n_vec++;
            if (press_o !== (i == 7)) begin
                n_err++;
                $display("FAIL press_latency[%0d] press_o=%b expected=%b", i, press_o, (i == 7));
            end
            n_vec++;
            if (level_o !== (i == 7)) begin
                n_err++;
                $display("FAIL press_level[%0d] level_o=%b expected=%b", i, level_o, (i == 7));
            end
        end
        n_vec++;
        if (pend_o !== 1'b1) begin
            n_err++;
            $display("FAIL press_pend pend_o=%b expected=1", pend_o);
        end
    endtask

    task automatic test_long();
        for (int i = 1; i <= 40; i++) begin
            tick();
            n_vec++;
            if (long_o !== (i == 10)) begin
                n_err++;
                $display("FAIL long_strobe[%0d] long_o=%b expected=%b", i, long_o, (i == 10));
            end
            n_vec++;
            if ({press_o, release_o, level_o} !== 3'b001) begin
                n_err++;
                $display("FAIL long_other[%0d] press,release,level=%b expected=001", i,
                         {press_o, release_o, level_o});
            end
        end
    endtask

    task automatic test_release();
        btn_i = 1'b1;
        repeat (2) tick();
        btn_i = 1'b0;
        repeat (2) tick();
        n_vec++;
        if ({level_o, release_o} !== 2'b10) begin
            n_err++;
            $display("FAIL release_glitch level,release=%b expected=10", {level_o, release_o});
        end
        btn_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_vec++;
            if (release_o !== (i == 7)) begin
                n_err++;
                $display("FAIL release_strobe[%0d] release_o=%b expected=%b", i, release_o, (i == 7));
            end
            n_vec++;
            if (level_o !== (i < 7)) begin
                n_err++;
                $display("FAIL release_level[%0d] level_o=%b expected=%b", i, level_o, (i < 7));
            end
        end
    endtask

    task automatic test_bounce();
        int bad = 0;
        for (int r = 0; r < 5; r++) begin
            btn_i = 1'b0;
            for (int k = 0; k < 5; k++) begin
                if (k == 3) btn_i = 1'b1;
                tick();
                if (press_o !== 1'b0 || level_o !== 1'b0) bad++;
            end
        end
        btn_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (press_o !== 1'b0 || level_o !== 1'b0) bad++;
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL bounce_reject bad_cycles=%0d expected=0", bad);
        end
    endtask

    task automatic test_handshake();
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        n_vec++;
        if (pend_o !== 1'b0) begin
            n_err++;
            $display("FAIL ack_clear pend_o=%b expected=0", pend_o);
        end
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        n_vec++;
        if (pend_o !== 1'b0) begin
            n_err++;
            $display("FAIL ack_idle pend_o=%b expected=0", pend_o);
        end
        btn_i = 1'b0;
        repeat (7) tick();
        n_vec++;
        if ({press_o, pend_o} !== 2'b11) begin
            n_err++;
            $display("FAIL hs_press press,pend=%b expected=11", {press_o, pend_o});
        end
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        n_vec++;
        if (pend_o !== 1'b1) begin
            n_err++;
            $display("FAIL hs_set_wins pend_o=%b expected=1", pend_o);
        end
        repeat (3) tick();
        n_vec++;
        if (pend_o !== 1'b1) begin
            n_err++;
            $display("FAIL hs_sticky pend_o=%b expected=1", pend_o);
        end
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        n_vec++;
        if (pend_o !== 1'b0) begin
            n_err++;
            $display("FAIL hs_late_ack pend_o=%b expected=0", pend_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] outs;
        btn_i = 1'b1;
        repeat (10) tick();
        btn_i = 1'b0;
        repeat (4) tick();
        rst_i = 1'b0;
        #1;
        outs = {level_o, press_o, release_o, long_o, pend_o};
        n_vec++;
        if (outs !== 5'b0) begin
            n_err++;
            $display("FAIL rst_conf outs=%b expected=%b", outs, 5'b0);
        end
        repeat (2) tick();
        rst_i = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            n_vec++;
            if (press_o !== (i == 7)) begin
                n_err++;
                $display("FAIL rst_conf_repress[%0d] press_o=%b expected=%b", i, press_o, (i == 7));
            end
        end
        repeat (3) tick();
        rst_i = 1'b0;
        #1;
        outs = {level_o, press_o, release_o, long_o, pend_o};
        n_vec++;
        if (outs !== 5'b0) begin
            n_err++;
            $display("FAIL rst_pressed outs=%b expected=%b", outs, 5'b0);
        end
        tick();
        rst_i = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            n_vec++;
            if (press_o !== (i == 7)) begin
                n_err++;
                $display("FAIL rst_pressed_repress[%0d] press_o=%b expected=%b", i, press_o, (i == 7));
            end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_long();
        test_release();
        test_bounce();
        test_handshake();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
